wb_bram: RTL and testbench

Synthesizable Wishbone responder (slave) backed by an on-chip block RAM, attached to one slave port of the `conbus` interconnect. Serves classic single-word cycles and CTI incrementing bursts with zero wait states inside a burst, with per-byte write enables. It is the responder end of the same Wishbone bus that the SoC masters initiate on.

---
 rtl/wb_bram.sv | 103 ++++++++++
 tb/tb_wb_bram.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bram.sv
// Wishbone responder backed by a byte-writable block RAM.
// Classic cycles take two clocks per word; CTI incrementing bursts stream one word per clock.
module wb_bram #(
   parameter int adr_width = 11
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [31:0] wb_adr_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o
);

   localparam int depth = 1 << adr_width;
   localparam logic [2:0] CTI_INC = 3'b010;
   localparam logic [2:0] CTI_END = 3'b111;

   typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

   state_t               state, state_nxt;
   logic [31:0]          mem [depth];
   logic [adr_width-1:0] ptr, idx, rd_adr;
   logic                 req, ld_ptr, inc_ptr, rd_en, wr_en, ack_nxt;
   logic                 unused_adr;

   assign idx = wb_adr_i[adr_width+1:2];
   assign req = wb_cyc_i & wb_stb_i;
   // Bits outside the word index were already decoded by the interconnect.
   assign unused_adr = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

   always_comb begin
      state_nxt = state;
      ack_nxt   = 1'b0;
      ld_ptr    = 1'b0;
      inc_ptr   = 1'b0;
      rd_en     = 1'b0;
      rd_adr    = idx;
      wr_en     = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               ld_ptr    = 1'b1;
               rd_en     = 1'b1;
               ack_nxt   = 1'b1;
               state_nxt = (wb_cti_i == CTI_INC) ? BURST : SINGLE;
            end
         end
         SINGLE: begin
            // Ack always drops here so a still-held strobe is not accepted twice.
            wr_en     = wb_ack_o & req & wb_we_i;
            state_nxt = IDLE;
         end
         BURST: begin
            if (!req) begin
               state_nxt = IDLE;
            end else if (wb_cti_i == CTI_END) begin
               wr_en     = wb_ack_o & wb_we_i;
               state_nxt = IDLE;
            end else begin
               // Prefetch the next word while the current one is written.
               wr_en   = wb_ack_o & wb_we_i;
               inc_ptr = 1'b1;
               rd_en   = 1'b1;
               rd_adr  = ptr + 1'b1;
               ack_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         ptr      <= '0;
         wb_ack_o <= 1'b0;
         wb_dat_o <= 32'h0;
      end else begin
         state    <= state_nxt;
         wb_ack_o <= ack_nxt;
         if (ld_ptr)
            ptr <= idx;
         else if (inc_ptr)
            ptr <= ptr + 1'b1;
         if (rd_en)
            wb_dat_o <= mem[rd_adr];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (wr_en && !sys_rst) begin
         for (int b = 0; b < 4; b++)
            if (wb_sel_i[b])
               mem[ptr][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_wb_bram.sv
// Bench for wb_bram: directed scenarios plus random traffic against a word-array model.
// A second instance with adr_width=4 covers pointer wrap-around.
module tb_wb_bram;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [31:0] adr = '0, dat_w = '0;
   logic [2:0]  cti = '0;
   logic [3:0]  sel = '0;
   logic        we = 1'b0, cyc = 1'b0, stb = 1'b0, use_small = 1'b0;
   logic [31:0] dat_b, dat_s, dat;
   logic        ack_b, ack_s, ack, cyc_b, cyc_s;

   int errors = 0;
   int checks = 0;
   int cyc_cnt = 0;

   logic [31:0] mdl_b [2048];
   logic [31:0] mdl_s [16];
   logic [31:0] bdat [64];
   logic [31:0] rbuf [64];

   assign cyc_b = cyc & ~use_small;
   assign cyc_s = cyc & use_small;
   assign ack   = use_small ? ack_s : ack_b;
   assign dat   = use_small ? dat_s : dat_b;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc_cnt++;

   wb_bram u_dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .wb_adr_i(adr), .wb_cti_i(cti),
      .wb_dat_i(dat_w), .wb_dat_o(dat_b), .wb_sel_i(sel), .wb_we_i(we),
      .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_ack_o(ack_b)
   );

   wb_bram #(.adr_width(4)) u_small (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .wb_adr_i(adr), .wb_cti_i(cti),
      .wb_dat_i(dat_w), .wb_dat_o(dat_s), .wb_sel_i(sel), .wb_we_i(we),
      .wb_cyc_i(cyc_s), .wb_stb_i(stb), .wb_ack_o(ack_s)
   );

   function automatic int dmask();
      return use_small ? 15 : 2047;
   endfunction

   function automatic logic [31:0] mdl_rd(int w);
      return use_small ? mdl_s[w & 15] : mdl_b[w & 2047];
   endfunction

   task automatic mdl_wr(input int w, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] v;
      v = mdl_rd(w);
      for (int b = 0; b < 4; b++)
         if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      if (use_small) mdl_s[w & 15] = v;
      else           mdl_b[w & 2047] = v;
   endtask

   // Byte address for a word, with junk in the bits the responder must ignore.
   function automatic logic [31:0] mkadr(int w);
      logic [31:0] junk;
      junk = $urandom;
      return (32'(w & dmask()) << 2) | (junk << (use_small ? 6 : 13)) | 32'($urandom_range(0, 3));
   endfunction

   task automatic classic(input logic w, input int word, input logic [31:0] d, input logic [3:0] s,
                          output logic a0, output logic a1, output logic a2, output logic [31:0] rd);
      a0 = ack;
      adr = mkadr(word); we = w; dat_w = d; sel = s; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
      @(posedge sys_clk); #1;
      a1 = ack; rd = dat;
      @(posedge sys_clk); #1;
      a2 = ack;
      if (w) mdl_wr(word, d, s);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic burst(input logic w, input int start, input int n, input logic [3:0] s,
                        output int nack, output logic a0, output logic alast);
      a0 = ack; nack = 0;
      adr = mkadr(start); we = w; sel = s; dat_w = bdat[0];
      cti = (n == 1) ? 3'b000 : 3'b010; cyc = 1'b1; stb = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge sys_clk); #1;
         if (ack) nack++;
         rbuf[i] = dat;
         if (i > 0 && w) mdl_wr(start + i - 1, bdat[i-1], s);
         dat_w = bdat[i];
         cti = (i == n - 1) ? 3'b111 : 3'b010;
         adr = $urandom;
      end
      @(posedge sys_clk); #1;
      alast = ack;
      if (w) mdl_wr(start + n - 1, bdat[n-1], s);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack_b); end
      checks++; if (dat_b !== 32'h0) begin errors++; $display("FAIL reset_dat got=%h exp=0", dat_b); end
      checks++; if (ack_s !== 1'b0 || dat_s !== 32'h0) begin
         errors++; $display("FAIL reset_small got ack=%b dat=%h exp ack=0 dat=0", ack_s, dat_s);
      end
      sys_rst = 1'b0;
      @(posedge sys_clk); #1;
   endtask

   task automatic test_classic();
      logic a0, a1, a2;
      logic [31:0] rd;
      classic(1'b1, 32'h10 >> 2, 32'hDEADBEEF, 4'hF, a0, a1, a2, rd);
      checks++; if ({a0, a1, a2} !== 3'b010) begin errors++; $display("FAIL classic_wr_ack got=%b exp=010", {a0, a1, a2}); end
      classic(1'b0, 32'h10 >> 2, 32'h0, 4'hF, a0, a1, a2, rd);
      checks++; if ({a0, a1, a2} !== 3'b010) begin errors++; $display("FAIL classic_rd_ack got=%b exp=010", {a0, a1, a2}); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL classic_rd_data got=%h exp=deadbeef", rd); end
   endtask

   task automatic test_byte_mask();
      logic a0, a1, a2;
      logic [31:0] rd;
      classic(1'b1, 32'h20 >> 2, 32'h11223344, 4'b1111, a0, a1, a2, rd);
      classic(1'b1, 32'h20 >> 2, 32'hAABBCCDD, 4'b0101, a0, a1, a2, rd);
      classic(1'b0, 32'h20 >> 2, 32'h0, 4'b1111, a0, a1, a2, rd);
      checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL byte_mask got=%h exp=11bb33dd", rd); end
   endtask

   task automatic test_burst();
      int nack;
      logic a0, al;
      for (int i = 0; i < 4; i++) bdat[i] = 32'(i + 1);
      burst(1'b1, 32'h100 >> 2, 4, 4'hF, nack, a0, al);
      checks++; if (nack != 4 || a0 !== 1'b0 || al !== 1'b0) begin
         errors++; $display("FAIL burst_wr_ack got nack=%0d pre=%b post=%b exp nack=4 pre=0 post=0", nack, a0, al);
      end
      burst(1'b0, 32'h100 >> 2, 4, 4'hF, nack, a0, al);
      checks++; if (nack != 4 || al !== 1'b0) begin
         errors++; $display("FAIL burst_rd_ack got nack=%0d post=%b exp nack=4 post=0", nack, al);
      end
      for (int i = 0; i < 4; i++) begin
         checks++; if (rbuf[i] !== 32'(i + 1)) begin errors++; $display("FAIL burst_rd_data[%0d] got=%h exp=%h", i, rbuf[i], i + 1); end
      end
   endtask

   task automatic test_wrap();
      logic a0, a1, a2, al;
      logic [31:0] rd, exp4 [4];
      int nack;
      use_small = 1'b1;
      classic(1'b1, 15, 32'hF00D000F, 4'hF, a0, a1, a2, rd);
      classic(1'b1, 0,  32'hF00D0000, 4'hF, a0, a1, a2, rd);
      classic(1'b1, 1,  32'hF00D0001, 4'hF, a0, a1, a2, rd);
      burst(1'b0, 15, 3, 4'hF, nack, a0, al);
      checks++; if (rbuf[0] !== 32'hF00D000F || rbuf[1] !== 32'hF00D0000 || rbuf[2] !== 32'hF00D0001) begin
         errors++; $display("FAIL wrap_rd got=%h %h %h exp=f00d000f f00d0000 f00d0001", rbuf[0], rbuf[1], rbuf[2]);
      end
      for (int i = 0; i < 4; i++) bdat[i] = $urandom;
      burst(1'b1, 14, 4, 4'hF, nack, a0, al);
      for (int i = 0; i < 4; i++) exp4[i] = mdl_rd(14 + i);
      burst(1'b0, 14, 4, 4'hF, nack, a0, al);
      for (int i = 0; i < 4; i++) begin
         checks++; if (rbuf[i] !== exp4[i]) begin errors++; $display("FAIL wrap_wr[%0d] got=%h exp=%h", i, rbuf[i], exp4[i]); end
      end
      use_small = 1'b0;
   endtask

   task automatic test_abort();
      logic a0, a1, a2, k1, k2, k3;
      logic [31:0] rd;
      for (int i = 0; i < 3; i++) classic(1'b1, 128 + i, 32'hC0DE0000 + 32'(i), 4'hF, a0, a1, a2, rd);
      adr = mkadr(128); we = 1'b1; sel = 4'hF; dat_w = 32'hA0A00000; cti = 3'b010; cyc = 1'b1; stb = 1'b1;
      @(posedge sys_clk); #1; k1 = ack;
      @(posedge sys_clk); #1; k2 = ack; dat_w = 32'hA0A00001;
      @(posedge sys_clk); #1; k3 = ack; dat_w = 32'hA0A00002; stb = 1'b0;
      @(posedge sys_clk); #1;
      checks++; if ({k1, k2, k3, ack} !== 4'b1110) begin
         errors++; $display("FAIL abort_ack got=%b exp=1110", {k1, k2, k3, ack});
      end
      cyc = 1'b0; we = 1'b0; cti = 3'b000;
      mdl_wr(128, 32'hA0A00000, 4'hF);
      mdl_wr(129, 32'hA0A00001, 4'hF);
      classic(1'b0, 128, 32'h0, 4'hF, a0, a1, a2, rd);
      checks++; if (rd !== 32'hA0A00000 || a1 !== 1'b1) begin errors++; $display("FAIL abort_w0 got=%h ack=%b exp=a0a00000 ack=1", rd, a1); end
      classic(1'b0, 129, 32'h0, 4'hF, a0, a1, a2, rd);
      checks++; if (rd !== 32'hA0A00001) begin errors++; $display("FAIL abort_w1 got=%h exp=a0a00001", rd); end
      classic(1'b0, 130, 32'h0, 4'hF, a0, a1, a2, rd);
      checks++; if (rd !== 32'hC0DE0002) begin errors++; $display("FAIL abort_w2 got=%h exp=c0de0002", rd); end
   endtask

   task automatic test_reset_mid_burst();
      logic a0, a1, a2;
      logic [31:0] rd;
      classic(1'b1, 192, 32'h5EED0000, 4'hF, a0, a1, a2, rd);
      classic(1'b1, 193, 32'h5EED0001, 4'hF, a0, a1, a2, rd);
      adr = mkadr(192); we = 1'b1; sel = 4'hF; dat_w = 32'hB0B00000; cti = 3'b010; cyc = 1'b1; stb = 1'b1;
      @(posedge sys_clk); #1;
      @(posedge sys_clk); #1; dat_w = 32'hB0B00001; sys_rst = 1'b1;
      @(posedge sys_clk); #1;
      checks++; if (ack !== 1'b0 || dat !== 32'h0) begin
         errors++; $display("FAIL rst_mid_burst got ack=%b dat=%h exp ack=0 dat=0", ack, dat);
      end
      sys_rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
      mdl_wr(192, 32'hB0B00000, 4'hF);
      @(posedge sys_clk); #1;
      classic(1'b0, 192, 32'h0, 4'hF, a0, a1, a2, rd);
      checks++; if (rd !== 32'hB0B00000) begin errors++; $display("FAIL rst_w0 got=%h exp=b0b00000", rd); end
      classic(1'b0, 193, 32'h0, 4'hF, a0, a1, a2, rd);
      checks++; if (rd !== 32'h5EED0001) begin errors++; $display("FAIL rst_w1 got=%h exp=5eed0001", rd); end
   endtask

   task automatic test_back_to_back();
      logic a0, a1, a2;
      logic [31:0] rd, ex;
      int c0;
      c0 = cyc_cnt;
      for (int i = 0; i < 4; i++) begin
         ex = mdl_rd(32'h100 / 4 + i);
         classic(1'b0, 32'h100 / 4 + i, 32'h0, 4'hF, a0, a1, a2, rd);
         checks++; if (rd !== ex || a1 !== 1'b1) begin errors++; $display("FAIL b2b_rd[%0d] got=%h exp=%h", i, rd, ex); end
      end
      checks++; if (cyc_cnt - c0 != 8) begin errors++; $display("FAIL b2b_cycles got=%0d exp=8", cyc_cnt - c0); end
   endtask

   task automatic test_random();
      logic a0, a1, a2, al;
      logic [31:0] rd, ex, exq [8];
      logic [3:0] s;
      int nack, w, n;
      for (int i = 0; i < 64; i++) bdat[i] = $urandom;
      burst(1'b1, 512, 64, 4'hF, nack, a0, al);
      checks++; if (nack != 64) begin errors++; $display("FAIL rnd_fill_ack got=%0d exp=64", nack); end
      for (int it = 0; it < 40; it++) begin
         s = 4'($urandom);
         case ($urandom_range(0, 3))
            0: begin
               classic(1'b1, $urandom_range(512, 575), $urandom, s, a0, a1, a2, rd);
               checks++; if ({a1, a2} !== 2'b10) begin errors++; $display("FAIL rnd_wr_ack got=%b exp=10", {a1, a2}); end
            end
            1: begin
               w = $urandom_range(512, 575);
               ex = mdl_rd(w);
               classic(1'b0, w, 32'h0, 4'hF, a0, a1, a2, rd);
               checks++; if (rd !== ex) begin errors++; $display("FAIL rnd_rd w=%0d got=%h exp=%h", w, rd, ex); end
            end
            2: begin
               n = $urandom_range(1, 8);
               w = $urandom_range(512, 576 - n);
               for (int i = 0; i < n; i++) bdat[i] = $urandom;
               burst(1'b1, w, n, s, nack, a0, al);
               checks++; if (nack != n || al !== 1'b0) begin errors++; $display("FAIL rnd_bwr got nack=%0d exp=%0d", nack, n); end
            end
            default: begin
               n = $urandom_range(1, 8);
               w = $urandom_range(512, 576 - n);
               for (int i = 0; i < n; i++) exq[i] = mdl_rd(w + i);
               burst(1'b0, w, n, 4'hF, nack, a0, al);
               for (int i = 0; i < n; i++) begin
                  checks++; if (rbuf[i] !== exq[i]) begin errors++; $display("FAIL rnd_brd w=%0d got=%h exp=%h", w + i, rbuf[i], exq[i]); end
               end
            end
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_classic();
      test_byte_mask();
      test_burst();
      test_wrap();
      test_abort();
      test_reset_mid_burst();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
